// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM mux/demux path.
package tdm_pkg;

   typedef enum logic {HUNT, RUN} tdm_state_t;

   localparam int unsigned TDM_N_CH_DEF = 4;
   localparam int unsigned TDM_W_DEF    = 8;

   // Channel index width; shared with the transmit-side mux.
   function automatic int unsigned ch_w(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// TDM receive bus: serial word input side plus parallel frame output side.
// Optional macro TDM_CH_STROBE_EN adds the per-channel strobe signals ch_we/ch_data.
interface tdm_demux_if #(
   parameter int unsigned N_CH = tdm_pkg::TDM_N_CH_DEF,
   parameter int unsigned W    = tdm_pkg::TDM_W_DEF
) ();
   import tdm_pkg::*;

   localparam int unsigned CW = ch_w(N_CH);

   logic              in_valid;
   logic              in_sync;
   logic [W-1:0]      in_data;
   logic [N_CH*W-1:0] out_data;
   logic              out_valid;
   logic [CW-1:0]     ch_idx;
   logic              locked;
   logic              sync_err;
`ifdef TDM_CH_STROBE_EN
   logic [N_CH-1:0]   ch_we;
   logic [W-1:0]      ch_data;

   modport master (
      output in_valid, in_sync, in_data,
      input  out_data, out_valid, ch_idx, locked, sync_err, ch_we, ch_data
   );
   modport slave (
      input  in_valid, in_sync, in_data,
      output out_data, out_valid, ch_idx, locked, sync_err, ch_we, ch_data
   );
`else
   modport master (
      output in_valid, in_sync, in_data,
      input  out_data, out_valid, ch_idx, locked, sync_err
   );
   modport slave (
      input  in_valid, in_sync, in_data,
      output out_data, out_valid, ch_idx, locked, sync_err
   );
`endif

endinterface

// File: rtl/tdm_demux_demux_1xn.sv
// 1:N demultiplexer: index plus enable to a one-hot write-enable vector.
module demux_1xn #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [IW-1:0] idx_i,
   input  logic          en_i,
   output logic [N-1:0]  we_o
);

   always_comb begin
      we_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (en_i && (idx_i == IW'(k))) we_o[k] = 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: routes serial words to channel slots, publishes whole frames.
// Optional macro TDM_CH_STROBE_EN enables the per-word ch_we/ch_data strobe outputs.
module tdm_demux #(
   parameter int unsigned N_CH = tdm_pkg::TDM_N_CH_DEF,
   parameter int unsigned W    = tdm_pkg::TDM_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   tdm_demux_if.slave  bus
);
   import tdm_pkg::*;

   localparam int unsigned CW = ch_w(N_CH);
   localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

   tdm_state_t              state_q, state_d;
   logic [CW-1:0]           ch_cnt_q, ch_cnt_d;
   logic [N_CH-2:0][W-1:0]  shadow_q;
   logic [N_CH*W-1:0]       out_data_q;
   logic                    out_valid_q, out_valid_d;
   logic                    sync_err_q, sync_err_d;
   logic                    wr_en;
   logic [CW-1:0]           wr_idx;
   logic [N_CH-1:0]         we;

   always_comb begin
      state_d     = state_q;
      ch_cnt_d    = ch_cnt_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = ch_cnt_q;
      if (bus.in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (bus.in_sync) begin
                  wr_en    = 1'b1;
                  wr_idx   = '0;
                  ch_cnt_d = CW'(1);
                  state_d  = RUN;
               end
            end
            RUN: begin
               if (bus.in_sync) begin
                  // Early sync restarts the frame on this word; the partial frame is abandoned.
                  sync_err_d = (ch_cnt_q != '0);
                  wr_en      = 1'b1;
                  wr_idx     = '0;
                  ch_cnt_d   = CW'(1);
               end else if (ch_cnt_q == '0) begin
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
               end else begin
                  wr_en = 1'b1;
                  if (ch_cnt_q == LAST_CH) begin
                     out_valid_d = 1'b1;
                     ch_cnt_d    = '0;
                  end else begin
                     ch_cnt_d = ch_cnt_q + CW'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   demux_1xn #(
      .N  (N_CH),
      .IW (CW)
   ) u_demux (
      .idx_i (wr_idx),
      .en_i  (wr_en),
      .we_o  (we)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         ch_cnt_q    <= '0;
         shadow_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_cnt_q    <= ch_cnt_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
         for (int unsigned k = 0; k < N_CH - 1; k++) begin
            if (we[k]) shadow_q[k] <= bus.in_data;
         end
         // The last channel bypasses the shadow and lands directly in the published frame.
         if (out_valid_d) out_data_q <= {bus.in_data, shadow_q};
      end
   end

`ifdef TDM_CH_STROBE_EN
   logic [N_CH-1:0] ch_we_q;
   logic [W-1:0]    ch_data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch_we_q   <= '0;
         ch_data_q <= '0;
      end else begin
         ch_we_q <= we;
         if (wr_en) ch_data_q <= bus.in_data;
      end
   end

   assign bus.ch_we   = ch_we_q;
   assign bus.ch_data = ch_data_q;
`else
   logic unused_we;
   assign unused_we = we[N_CH-1];
`endif

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sync_err  = sync_err_q;
   assign bus.ch_idx    = ch_cnt_q;
   assign bus.locked    = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frame scenarios plus randomized traffic against a queue model.
module tb_tdm_demux;

   localparam int unsigned N = 4;
   localparam int unsigned WD = 8;

   typedef struct {
      bit          is_frame;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst_n;

   tdm_demux_if #(.N_CH(N), .W(WD)) bus ();

   tdm_demux #(.N_CH(N), .W(WD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   exp_t        exp_q[$];
   logic [7:0]  m_part[$];
   bit          m_locked;
   logic [31:0] m_last;
   logic [3:0]  exp_we;
   logic [7:0]  exp_chd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Frame-level reference: a word list per partial frame and a lock flag.
   function automatic void model_step(input logic v, input logic s, input logic [7:0] d);
      exp_t e;
      exp_we = '0;
      if (!v) return;
      if (s) begin
         if (m_locked && m_part.size() != 0) begin
            e.is_frame = 1'b0; e.data = '0;
            exp_q.push_back(e);
         end
         m_part.delete();
         m_part.push_back(d);
         m_locked = 1'b1;
         exp_we   = 4'b0001;
         exp_chd  = d;
      end else if (m_locked) begin
         if (m_part.size() == 0) begin
            e.is_frame = 1'b0; e.data = '0;
            exp_q.push_back(e);
            m_locked = 1'b0;
         end else begin
            exp_we  = 4'(1 << m_part.size());
            exp_chd = d;
            m_part.push_back(d);
            if (m_part.size() == N) begin
               for (int i = 0; i < N; i++) m_last[i*8 +: 8] = m_part[i];
               e.is_frame = 1'b1; e.data = m_last;
               exp_q.push_back(e);
               m_part.delete();
            end
         end
      end
   endfunction

   task automatic send(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_sync  = s;
      bus.in_data  = d;
      @(posedge clk);
      model_step(v, s, d);
      #1;
      chk("locked", 64'(bus.locked), 64'(m_locked));
      chk("ch_idx", 64'(bus.ch_idx), 64'(m_part.size()));
      chk("out_data_hold", 64'(bus.out_data), 64'(m_last));
`ifdef TDM_CH_STROBE_EN
      chk("ch_we", 64'(bus.ch_we), 64'(exp_we));
      if (exp_we != '0) chk("ch_data", 64'(bus.ch_data), 64'(exp_chd));
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = '0;
      @(posedge clk);
      m_part.delete();
      m_locked = 1'b0;
      m_last   = '0;
      exp_q.delete();
      #1;
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_sync_err", 64'(bus.sync_err), 64'd0);
      chk("rst_locked", 64'(bus.locked), 64'd0);
      chk("rst_ch_idx", 64'(bus.ch_idx), 64'd0);
`ifdef TDM_CH_STROBE_EN
      chk("rst_ch_we", 64'(bus.ch_we), 64'd0);
      chk("rst_ch_data", 64'(bus.ch_data), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every output pulse must match the oldest outstanding model event.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid && bus.sync_err) begin
            n_cmp++; n_err++;
            $display("FAIL pulse_overlap: out_valid and sync_err both 1 at %0t", $time);
         end else if (bus.out_valid || bus.sync_err) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_pulse: out_valid=%0b sync_err=%0b, none expected at %0t",
                        bus.out_valid, bus.sync_err, $time);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", 64'(bus.out_valid), 64'(e.is_frame));
               if (e.is_frame) chk("frame_data", 64'(bus.out_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      logic s;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = '0;
      m_locked     = 1'b0;
      m_last       = '0;
      exp_we       = '0;
      exp_chd      = '0;
      do_reset();

      // Basic frame, 1-cycle latency to out_valid.
      send(1, 1, 8'h11); send(1, 0, 8'h22); send(1, 0, 8'h33); send(1, 0, 8'h44);
      chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_out_data", 64'(bus.out_data), 64'h44332211);
      chk("t1_locked", 64'(bus.locked), 64'd1);

      // Same frame with stall gaps between words.
      send(1, 1, 8'h11); send(0, 1, 8'hEE);
      send(1, 0, 8'h22); send(0, 0, 8'hEE);
      send(1, 0, 8'h33); send(0, 0, 8'hEE);
      chk("t2_no_early_valid", 64'(bus.out_valid), 64'd0);
      send(1, 0, 8'h44);
      chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_out_data", 64'(bus.out_data), 64'h44332211);

      // Early sync abandons the A frame.
      send(1, 1, 8'hA0); send(1, 0, 8'hA1);
      send(1, 1, 8'hB0);
      chk("t3_sync_err", 64'(bus.sync_err), 64'd1);
      chk("t3_no_valid", 64'(bus.out_valid), 64'd0);
      send(1, 0, 8'hB1); send(1, 0, 8'hB2); send(1, 0, 8'hB3);
      chk("t3_out_data", 64'(bus.out_data), 64'hB3B2B1B0);

      // Missing sync at frame boundary drops lock.
      send(1, 0, 8'h55);
      chk("t4_sync_err", 64'(bus.sync_err), 64'd1);
      chk("t4_unlocked", 64'(bus.locked), 64'd0);
      send(1, 0, 8'h66); send(1, 0, 8'h77);
      chk("t4_still_hunt", 64'(bus.locked), 64'd0);
      send(1, 1, 8'hC0); send(1, 0, 8'hC1); send(1, 0, 8'hC2); send(1, 0, 8'hC3);
      chk("t4_relock_data", 64'(bus.out_data), 64'hC3C2C1C0);

      // Early sync on the last channel slot.
      send(1, 1, 8'hD0); send(1, 0, 8'hD1); send(1, 0, 8'hD2); send(1, 1, 8'hE0);
      chk("t4b_sync_err", 64'(bus.sync_err), 64'd1);
      chk("t4b_no_valid", 64'(bus.out_valid), 64'd0);
      send(1, 0, 8'hE1); send(1, 0, 8'hE2); send(1, 0, 8'hE3);

      // Reset mid-frame.
      send(1, 1, 8'h01); send(1, 0, 8'h02);
      do_reset();
      send(1, 0, 8'h03);
      chk("t5_hunt_after_rst", 64'(bus.locked), 64'd0);

      // Randomized traffic with occasional sync faults and stalls.
      for (int i = 0; i < 3000; i++) begin
         if (m_locked && m_part.size() != 0)
            s = ($urandom_range(0, 99) < 6);
         else
            s = ($urandom_range(0, 99) < 88);
         send(($urandom_range(0, 99) < 70), s, 8'($urandom));
      end

      send(0, 0, 8'h00);
      send(0, 0, 8'h00);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
